// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port between requesters A and B, and tracks pending writes per register.
// Optional REGFILE_WB_BYPASS_EN adds forwarding of the in-flight write to the decode sources.
module regfile_wb_scheduler #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_waddr,
  output logic          iss_ready,
  input  logic          a_valid,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_waddr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          hazard,
  output logic          err,
`ifdef REGFILE_WB_BYPASS_EN
  output logic          byp_hit1,
  output logic          byp_hit2,
  output logic [DW-1:0] byp_data1,
  output logic [DW-1:0] byp_data2,
`endif
  output logic          WrEn_RF,
  output logic [AW-1:0] WAddr_RF,
  output logic [DW-1:0] WD_RF
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                        rr_q, rr_d;   // 0: A wins a tie, 1: B wins
  logic                        err_q, err_d;
  logic                        wr_en_q, wr_en_d;
  wr_req_t                     wr_q, wr_d;
  logic [NREG-1:0][CNT_W-1:0]  cnt_q, cnt_d;

  logic                        gnt, iss_fire, inc, dec, underflow;
  wr_req_t                     gnt_req;
  logic [1:0][AW-1:0]          src;
  logic [1:0]                  src_inflight;

  always_comb begin
    // Ready is withheld during reset so a request on the bus is not consumed.
    a_ready  = reset_n & ~stall & a_valid & (~b_valid | ~rr_q);
    b_ready  = reset_n & ~stall & b_valid & (~a_valid |  rr_q);
    gnt      = a_ready | b_ready;
    gnt_req  = a_ready ? wr_req_t'{a_waddr, a_wdata} : wr_req_t'{b_waddr, b_wdata};

    rr_d     = a_ready ? 1'b1 : (b_ready ? 1'b0 : rr_q);
    wr_en_d  = gnt && (gnt_req.addr != '0);
    wr_d     = wr_en_d ? gnt_req : wr_q;

    iss_ready = iss_valid & (cnt_q[iss_waddr] != CNT_MAX);
    iss_fire  = iss_ready && (iss_waddr != '0);

    cnt_d     = cnt_q;
    cnt_d[0]  = '0;
    underflow = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc = iss_fire && (iss_waddr == AW'(r));
      dec = gnt && wr_en_d && (gnt_req.addr == AW'(r));
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (dec && !inc) begin
        if (cnt_q[r] == '0) underflow = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    err_d = err_q | underflow;

    // In-flight term: a same-cycle register-file read still returns the old value.
    src    = {rd_addr2, rd_addr1};
    hazard = 1'b0;
    for (int s = 0; s < 2; s++) begin
      src_inflight[s] = wr_en_q && (wr_q.addr == src[s]) && (src[s] != '0);
`ifdef REGFILE_WB_BYPASS_EN
      hazard = hazard | ((src[s] != '0) && (cnt_q[src[s]] != '0));
`else
      hazard = hazard | ((src[s] != '0) && ((cnt_q[src[s]] != '0) || src_inflight[s]));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      err_q   <= err_d;
      wr_en_q <= wr_en_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err      = err_q;
  assign WrEn_RF  = wr_en_q;
  assign WAddr_RF = wr_q.addr;
  assign WD_RF    = wr_q.data;

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_hit1  = src_inflight[0];
  assign byp_hit2  = src_inflight[1];
  assign byp_data1 = wr_q.data;
  assign byp_data2 = wr_q.data;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reset, round-robin, scoreboard, saturation, stall/r0, underflow, bypass.
module tb_regfile_wb_scheduler;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n, stall, iss_valid, iss_ready;
  logic [AW-1:0] iss_waddr, a_waddr, b_waddr, rd_addr1, rd_addr2, WAddr_RF;
  logic          a_valid, a_ready, b_valid, b_ready, hazard, err, WrEn_RF;
  logic [DW-1:0] a_wdata, b_wdata, WD_RF;
`ifdef REGFILE_WB_BYPASS_EN
  logic          byp_hit1, byp_hit2;
  logic [DW-1:0] byp_data1, byp_data2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr), .iss_ready(iss_ready),
    .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard(hazard), .err(err),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
    .WrEn_RF(WrEn_RF), .WAddr_RF(WAddr_RF), .WD_RF(WD_RF)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; iss_valid = 0; stall = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; stall = 0; iss_valid = 0; iss_waddr = 0;
    a_valid = 1; a_waddr = 5; a_wdata = 32'h55;
    b_valid = 0; b_waddr = 0; b_wdata = 0;
    rd_addr1 = 0; rd_addr2 = 0;
    tick(); tick();

    // reset state with A requesting
    chk("rst_a_ready", a_ready, 0);
    chk("rst_wren", WrEn_RF, 0);
    chk("rst_waddr", WAddr_RF, 0);
    chk("rst_wd", WD_RF, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_err", err, 0);
    reset_n = 1;
    #1 chk("rel_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    chk("rel_wren", WrEn_RF, 1);
    chk("rel_waddr", WAddr_RF, 5);
    chk("rel_wd", WD_RF, 32'h55);
    chk("rel_underflow_err", err, 1);
    tick();
    chk("rel_wren_drop", WrEn_RF, 0);
    chk("rel_waddr_hold", WAddr_RF, 5);
    do_reset();
    chk("rst2_err", err, 0);

    // tie: reserve r3,r4 twice each, then A/B alternate
    iss_valid = 1; iss_waddr = 3; tick(); tick();
    iss_waddr = 4; tick(); tick();
    iss_valid = 0;
    a_valid = 1; a_waddr = 3; a_wdata = 32'hA3;
    b_valid = 1; b_waddr = 4; b_wdata = 32'hB4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tie_a_ready%0d", i), a_ready, (i % 2) == 0);
      chk($sformatf("tie_b_ready%0d", i), b_ready, (i % 2) == 1);
      tick();
      chk($sformatf("tie_wren%0d", i), WrEn_RF, 1);
      chk($sformatf("tie_waddr%0d", i), WAddr_RF, (i % 2) ? 4 : 3);
      chk($sformatf("tie_wd%0d", i), WD_RF, (i % 2) ? 32'hB4 : 32'hA3);
    end
    a_valid = 0; b_valid = 0;
    #1 chk("tie_err", err, 0);

    // scoreboard hazard on r7
    iss_valid = 1; iss_waddr = 7;
    #1 chk("sb_iss_ready", iss_ready, 1);
    tick();
    iss_valid = 0; rd_addr1 = 7;
    #1 chk("sb_hazard_pending", hazard, 1);
    a_valid = 1; a_waddr = 7; a_wdata = 32'h77;
    #1 chk("sb_hazard_grant_cycle", hazard, 1);
    tick();
    a_valid = 0;
`ifdef REGFILE_WB_BYPASS_EN
    #1 chk("sb_hazard_inflight", hazard, 0);
    chk("sb_byp_hit1", byp_hit1, 1);
`else
    #1 chk("sb_hazard_inflight", hazard, 1);
`endif
    tick();
    chk("sb_hazard_clear", hazard, 0);
    rd_addr1 = 0;

    // saturation on r9, decrement via B in the same cycle as a refused issue
    iss_valid = 1; iss_waddr = 9;
    tick(); tick(); tick();
    chk("sat_iss_ready_full", iss_ready, 0);
    b_valid = 1; b_waddr = 9; b_wdata = 32'h99;
    #1 chk("sat_b_ready", b_ready, 1);
    chk("sat_iss_ready_grant", iss_ready, 0);
    tick();
    b_valid = 0;
    chk("sat_wd", WD_RF, 32'h99);
    chk("sat_iss_ready_2", iss_ready, 1);
    iss_valid = 0; rd_addr2 = 9;
    #1 chk("sat_hazard_r9", hazard, 1);
    chk("sat_err", err, 0);
    rd_addr2 = 0;
    do_reset();

    // stall blocks grants
    stall = 1; a_valid = 1; a_waddr = 0; a_wdata = 32'h1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("stall_a_ready%0d", i), a_ready, 0);
      tick();
      chk($sformatf("stall_wren%0d", i), WrEn_RF, 0);
    end
    stall = 0;
    #1 chk("r0_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    chk("r0_wren", WrEn_RF, 0);
    chk("r0_err", err, 0);
    a_valid = 1; a_waddr = 12; a_wdata = 32'hC;
    tick();
    a_valid = 0;
    chk("uf_err", err, 1);
    tick(); tick();
    chk("uf_err_sticky", err, 1);
    do_reset();
    chk("uf_err_cleared", err, 0);

`ifdef REGFILE_WB_BYPASS_EN
    iss_valid = 1; iss_waddr = 6; tick();
    iss_valid = 0;
    a_valid = 1; a_waddr = 6; a_wdata = 32'hDEADBEEF;
    tick();
    a_valid = 0; rd_addr2 = 6;
    #1 chk("byp_hit2", byp_hit2, 1);
    chk("byp_data2", byp_data2, 32'hDEADBEEF);
    chk("byp_hit1", byp_hit1, 0);
    chk("byp_hazard", hazard, 0);
    rd_addr2 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/early pipe) and B (load/multi-cycle unit).
- Drives WrEn_RF/WAddr_RF/WD_RF from registered outputs.
- Keeps a per-register pending-write scoreboard fed by the issue stage. Raises a read hazard when a source register has an outstanding or in-flight write.
- Sits between the execute/writeback stages and the register file.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired zero
AW, 5, register address width
DW, 32, write data width
CNT_W, 2, width of each pending-write counter; maximum count is 2^CNT_W-1

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous, active-low reset
stall  in  1  pipeline stall; blocks all grants while high
iss_valid  in  1  issue stage reserves a destination register
iss_waddr  in  AW  destination register being reserved
iss_ready  out  1  reservation accepted this cycle
a_valid  in  1  requester A has a write
a_waddr  in  AW  requester A destination
a_wdata  in  DW  requester A data
a_ready  out  1  requester A granted this cycle
b_valid  in  1  requester B has a write
b_waddr  in  AW  requester B destination
b_wdata  in  DW  requester B data
b_ready  out  1  requester B granted this cycle
rd_addr1  in  AW  decode source register 1
rd_addr2  in  AW  decode source register 2
hazard  out  1  a decode source has an outstanding or in-flight write
err  out  1  sticky protocol error
WrEn_RF  out  1  register-file write enable (registered)
WAddr_RF  out  AW  register-file write address (registered)
WD_RF  out  DW  register-file write data (registered)

Behaviour:
- Reset: when reset_n=0 at a clk edge:
  - all counters go to 0; WrEn_RF=0, WAddr_RF=0, WD_RF=0; err=0; round-robin pointer favours A.
  - Reset mid-operation discards all pending state; a request already on the bus is not granted in the reset cycle.
- Handshake:
  - A requester holds valid, waddr and wdata stable until it sees ready=1. ready is a combinational function of valid.
  - ready=1 means the request is consumed at that edge.
- Arbitration:
  - No grant while stall=1.
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin. The pointer toggles to the other requester after every grant. After reset, A wins the first tie.
- Write output (1-cycle latency):
  - The cycle after a grant: WrEn_RF=1, WAddr_RF/WD_RF = the granted address/data, for exactly one cycle.
  - Otherwise WrEn_RF=0 and WAddr_RF/WD_RF hold their previous values.
  - A grant with waddr=0 is consumed but produces WrEn_RF=0.
- Scoreboard:
  - Each register 1..NREG-1 has a CNT_W-bit counter.
  - Increment on iss_valid & iss_ready & iss_waddr!=0.
  - Decrement on a grant with waddr!=0.
  - Increment and decrement of the same register in one cycle: net unchanged.
  - Register 0 is never counted.
- iss_ready = iss_valid & (count[iss_waddr] != max). It does not depend on stall.
- Decrement of a counter already at 0: the counter stays 0 and err is set, held until reset.
- hazard = OR over s in {rd_addr1, rd_addr2} of (s!=0 & (count[s]!=0 | (WrEn_RF & WAddr_RF==s))). The in-flight term is needed because a register-file read in the same cycle returns the old value.
- Hazard ignores grants made in the current cycle: the counter is still nonzero until the next edge.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds outputs byp_hit1, byp_hit2 (1 bit each) and byp_data1, byp_data2 (DW each).
  - byp_hitN = WrEn_RF & WAddr_RF==rd_addrN & rd_addrN!=0.
  - byp_dataN = WD_RF.
  - The in-flight term is removed from hazard for a source that hits the bypass. The count term still applies to that source.
- Not defined: the bypass ports are absent and hazard is exactly as specified above.

Test Plan:
- Reset: hold reset_n=0 with a_valid=1, a_waddr=5 -> no a_ready, WrEn_RF=0, WAddr_RF=0, WD_RF=0, hazard=0, err=0; release -> a_ready=1 that cycle, next cycle WrEn_RF=1, WAddr_RF=5.
- Tie: a_valid=b_valid=1 held for 4 cycles (A to r3, B to r4) -> grants A,B,A,B; WrEn_RF pulses 1 cycle after each grant with WAddr_RF 3,4,3,4.
- Scoreboard: issue r7 (count 0->1), rd_addr1=7 -> hazard=1; grant a write to r7 -> hazard still 1 next cycle (in-flight); following cycle hazard=0.
- Saturation (CNT_W=2): three issues to r9 -> count 3; fourth iss_valid to r9 -> iss_ready=0. Same cycle as a grant to r9 -> iss_ready still 0, count becomes 2.
- Stall and r0: stall=1 with a_valid=1 for 3 cycles -> a_ready=0, WrEn_RF=0; grant with a_waddr=0 -> a_ready=1, WrEn_RF stays 0, no err. Grant to r12 with count 0 -> err=1, held until reset.
- Bypass build: WrEn_RF=1, WAddr_RF=6, WD_RF=0xDEADBEEF, rd_addr2=6, count[6]=0 -> byp_hit2=1, byp_data2=0xDEADBEEF, hazard=0.
